imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Pipelined RV32I immediate encoder; the inverse of the immediate decode path.
- Takes an instruction template, a 32-bit immediate value and a format select, then scatters the immediate into the format's instruction bit positions.
- Checks that the immediate is representable in the selected format and flags it if not.
- Used by the program loader/patcher and the self-check bench. Valid/ready on both sides; 2-stage pipeline.

Parameters:
- size, 32, instruction/immediate width; only 32 is supported.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder accepts a request this cycle.
- in_template  input  size  instruction word; the non-immediate bits are kept.
- in_imm  input  size  immediate value, two's complement.
- IMM_sel  input  3  format: 0=I, 1=S, 2=B, 3=U, 4=J, 5-7 invalid.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_instr  output  size  encoded instruction.
- out_err  output  1  range, alignment or select error for this result.
- err_count  output  ERR_CNT_W  number of errored results accepted, saturating.

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - out_valid=0, out_instr=0, out_err=0, err_count=0, both stage valids 0.
  - in_ready=1 once reset is released.
- Handshake:
  - Transfer occurs when valid&&ready on a side.
  - Once out_valid=1, out_instr and out_err stay stable until the out_ready handshake.
  - in_ready must not depend combinationally on in_valid.
- Pipeline:
  - S1 registers template, imm, sel and the computed err.
  - S2 registers the packed out_instr and out_err.
  - Latency: 2 cycles from input transfer to out_valid with no stall.
  - Throughput: 1 per cycle when out_ready=1.
  - S2 loads when S2 is empty or out_ready=1.
  - S1 advances when S2 loads.
  - in_ready = !s1_valid || s2_can_load.
  - No loss or duplication under any out_ready pattern. Max 2 requests in flight.
- Field packing (bits not listed come from in_template):
  - I: instr[31:20]=imm[11:0].
  - S: instr[31:25]=imm[11:5], instr[11:7]=imm[4:0].
  - B: instr[31]=imm[12], instr[7]=imm[11], instr[30:25]=imm[10:5], instr[11:8]=imm[4:1].
  - U: instr[31:12]=imm[31:12].
  - J: instr[31]=imm[20], instr[30:21]=imm[10:1], instr[20]=imm[11], instr[19:12]=imm[19:12].
- Error rules:
  - I/S: error unless -2048 <= imm <= 2047, i.e. imm[31:11] all equal.
  - B: error unless imm[31:12] all equal and imm[0]=0.
  - U: error unless imm[11:0]=0.
  - J: error unless imm[31:20] all equal and imm[0]=0.
  - sel 5-7: always an error.
- On error: out_instr=in_template unchanged (no partial patch) and out_err=1.
- err_count:
  - Increments on an output transfer with out_err=1.
  - Saturates at all-ones; it does not wrap.
- Simultaneous events: S1 load and S2 drain in the same cycle are legal, and the pipeline stays full.
- Reset mid-operation: in-flight requests are discarded, and out_valid drops asynchronously.
- Invariant: when out_err=0, decoding out_instr with the same sel yields in_imm exactly.

Test Plan:
- Reset then single I request: template=0x00000013, imm=0xFFFFF800 (-2048), sel=0, out_ready=1 -> after 2 cycles out_valid=1, out_instr=0x80000013, out_err=0, err_count=0.
- B encode: template=0x00000063, imm=0x00000FFE, sel=2 -> out_instr=0x7E000FE3, out_err=0. Same template with imm=0x00001001 -> out_instr=0x00000063, out_err=1, err_count=1.
- U/J: sel=3, imm=0x12345000, template=0x00000037 -> 0x12345037. Same request with imm=0x12345001 -> err. sel=4, imm=0x000FFFFE, template=0x0000006F -> 0x7FFFF06F. sel=6 with any imm -> err, template unchanged.
- Backpressure: stream 10 back-to-back requests while out_ready toggles 1,0,0,1,0,... -> all 10 results arrive in order with no drop or duplicate. in_ready=0 only when both stages are full and out_ready=0. Outputs stay stable while stalled.
- Saturation and reset: 300 errored transfers with ERR_CNT_W=8 -> err_count=255. Assert rst_n mid-stream with out_valid=1 -> out_valid=0 and err_count=0 immediately; the first post-reset request completes with 2-cycle latency.
- Random round-trip: 10k random imm/sel/template with random out_ready -> every non-error result decodes back to in_imm, template bits outside the field are unchanged, and the error flag matches the reference model.

Source files
------------

// File: rtl/imm_encoder.sv
// RV32I immediate encoder. It scatters an immediate into the field bits of the selected
// format and flags values that format cannot hold. Two stages with valid/ready on both sides.
module imm_encoder #(
    parameter int size      = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [size-1:0]      in_template,
    input  logic [size-1:0]      in_imm,
    input  logic [2:0]           IMM_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [size-1:0]      out_instr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [2:0] FMT_I = 3'd0;
    localparam logic [2:0] FMT_S = 3'd1;
    localparam logic [2:0] FMT_B = 3'd2;
    localparam logic [2:0] FMT_U = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;

    logic            s1_valid_q, s1_valid_d;
    logic [size-1:0] s1_tmpl_q, s1_imm_q;
    logic [2:0]      s1_sel_q;
    logic            s1_err_q;
    logic            s2_valid_q;
    logic [size-1:0] s2_instr_q;
    logic            s2_err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic            s2_load, s1_load;
    logic            in_err;
    logic            is_ok, b_ok, u_ok, j_ok;
    logic [size-1:0] pack_instr;

    assign s2_load  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign s1_load  = in_valid && in_ready;

    // A range check passes when all bits above the field's sign bit match that sign bit.
    assign is_ok = (&in_imm[31:11]) || !(|in_imm[31:11]);
    assign b_ok  = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
    assign u_ok  = !(|in_imm[11:0]);
    assign j_ok  = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];

    always_comb begin
        in_err = 1'b1;
        case (IMM_sel)
            FMT_I, FMT_S: in_err = !is_ok;
            FMT_B:        in_err = !b_ok;
            FMT_U:        in_err = !u_ok;
            FMT_J:        in_err = !j_ok;
            default:      in_err = 1'b1;
        endcase
    end

    // An errored request passes the template through untouched, so there is never a partial patch.
    always_comb begin
        pack_instr = s1_tmpl_q;
        if (!s1_err_q) begin
            case (s1_sel_q)
                FMT_I: pack_instr[31:20] = s1_imm_q[11:0];
                FMT_S: begin
                    pack_instr[31:25] = s1_imm_q[11:5];
                    pack_instr[11:7]  = s1_imm_q[4:0];
                end
                FMT_B: begin
                    pack_instr[31]    = s1_imm_q[12];
                    pack_instr[30:25] = s1_imm_q[10:5];
                    pack_instr[11:8]  = s1_imm_q[4:1];
                    pack_instr[7]     = s1_imm_q[11];
                end
                FMT_U: pack_instr[31:12] = s1_imm_q[31:12];
                FMT_J: begin
                    pack_instr[31]    = s1_imm_q[20];
                    pack_instr[30:21] = s1_imm_q[10:1];
                    pack_instr[20]    = s1_imm_q[11];
                    pack_instr[19:12] = s1_imm_q[19:12];
                end
                default: pack_instr = s1_tmpl_q;
            endcase
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (s1_load)      s1_valid_d = 1'b1;
        else if (s2_load) s1_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_tmpl_q  <= '0;
            s1_imm_q   <= '0;
            s1_sel_q   <= '0;
            s1_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_load) begin
                s1_tmpl_q <= in_template;
                s1_imm_q  <= in_imm;
                s1_sel_q  <= IMM_sel;
                s1_err_q  <= in_err;
            end
        end
    end

    // Output data only moves when a real result arrives, so it stays quiet between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_instr_q <= pack_instr;
                s2_err_q   <= s1_err_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt_q <= '0;
        else if (s2_valid_q && out_ready && s2_err_q && !(&err_cnt_q))
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end

    assign out_valid = s2_valid_q;
    assign out_instr = s2_instr_q;
    assign out_err   = s2_err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder. The driver queues expectations and the monitor checks each
// result by decoding it back to the immediate and comparing untouched template bits.
module tb_imm_encoder;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_template = '0, in_imm = '0;
    logic [2:0]  IMM_sel = '0;
    logic        out_valid, out_ready = 1'b0, out_err;
    logic [31:0] out_instr;
    logic [7:0]  err_count;

    typedef struct {
        logic [31:0] tmpl;
        logic [31:0] imm;
        logic [2:0]  sel;
        logic        err;
        logic        has_exp;
        logic [31:0] exp_instr;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0, checks = 0;
    int          model_cnt = 0;
    int          orq_mode = 0;
    bit          held = 0;
    logic [31:0] held_instr;
    logic        held_err;

    imm_encoder #(.size(32), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_template(in_template), .in_imm(in_imm), .IMM_sel(IMM_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Representability, from signed ranges and alignment.
    function automatic logic ref_err(input logic [31:0] imm, input logic [2:0] sel);
        longint s;
        s = longint'($signed(imm));
        case (sel)
            3'd0, 3'd1: return !(s >= -2048 && s <= 2047);
            3'd2:       return !(s >= -4096 && s <= 4094 && imm[0] == 1'b0);
            3'd3:       return (imm % 4096) != 0;
            3'd4:       return !(s >= -1048576 && s <= 1048574 && imm[0] == 1'b0);
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] field_mask(input logic [2:0] sel);
        case (sel)
            3'd0:       return 32'hFFF0_0000;
            3'd1, 3'd2: return 32'hFE00_0F80;
            3'd3, 3'd4: return 32'hFFFF_F000;
            default:    return 32'h0;
        endcase
    endfunction

    // Standard RV32I immediate decode.
    function automatic logic [31:0] dec(input logic [31:0] i, input logic [2:0] sel);
        case (sel)
            3'd0:    return {{20{i[31]}}, i[31:20]};
            3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3:    return {i[31:12], 12'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            model_cnt = 0;
            held = 0;
        end else begin
            if (held) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_instr", out_instr, held_instr);
                chk("stall_err", 32'(out_err), 32'(held_err));
            end
            if (out_ready || !out_valid) chk("in_ready", 32'(in_ready), 32'd1);
            if (out_valid && out_ready) begin
                held = 0;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_output: got %h with empty scoreboard", out_instr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_err", 32'(out_err), 32'(e.err));
                    if (e.err) begin
                        chk("err_passthru", out_instr, e.tmpl);
                    end else begin
                        chk("roundtrip", dec(out_instr, e.sel), e.imm);
                        chk("tmpl_bits", out_instr & ~field_mask(e.sel), e.tmpl & ~field_mask(e.sel));
                    end
                    if (e.has_exp) chk("directed_instr", out_instr, e.exp_instr);
                    chk("err_count", 32'(err_count), 32'(model_cnt));
                    if (e.err && model_cnt < 255) model_cnt++;
                end
            end else if (out_valid) begin
                held = 1;
                held_instr = out_instr;
                held_err = out_err;
            end else begin
                held = 0;
            end
        end
    end

    initial begin
        int c = 0;
        forever begin
            @(posedge clk); #1;
            case (orq_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin out_ready = (c % 3 == 0); c++; end
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [31:0] t, input logic [31:0] imm, input logic [2:0] sel,
                        input bit has, input logic [31:0] ex);
        exp_t e;
        int n = 0;
        in_template = t; in_imm = imm; IMM_sel = sel; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 1000) begin
                checks++; errors++;
                $display("FAIL send_timeout: in_ready stuck at %0b", in_ready);
                break;
            end
            @(posedge clk); #1;
        end
        if (n <= 1000) begin
            e.tmpl = t; e.imm = imm; e.sel = sel; e.err = ref_err(imm, sel);
            e.has_exp = has; e.exp_instr = ex;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(posedge clk); n++;
        end
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, 0 required", sb.size());
        end
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 3))
            0: return x;
            1: return {{19{x[12]}}, x[12:0]};
            2: return {{11{x[20]}}, x[20:0]};
            default: return x & 32'hFFFF_F000;
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        send(32'h0000_0013, 32'hFFFF_F800, 3'd0, 1, 32'h8000_0013);
        chk("lat_1cyc", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_2cyc", 32'(out_valid), 32'd1);
        drain();
        chk("cnt_after_ok", 32'(err_count), 32'd0);

        send(32'h0000_0063, 32'h0000_0FFE, 3'd2, 1, 32'h7E00_0FE3);
        send(32'h0000_0063, 32'h0000_1001, 3'd2, 1, 32'h0000_0063);
        drain();
        chk("cnt_after_b_err", 32'(err_count), 32'd1);

        send(32'h0000_0037, 32'h1234_5000, 3'd3, 1, 32'h1234_5037);
        send(32'h0000_0037, 32'h1234_5001, 3'd3, 1, 32'h0000_0037);
        send(32'h0000_006F, 32'h000F_FFFE, 3'd4, 1, 32'h7FFF_F06F);
        send(32'hDEAD_BEEF, $urandom, 3'd6, 1, 32'hDEAD_BEEF);
        send(32'h0000_0013, 32'h0000_07FF, 3'd0, 1, 32'h7FF0_0013);
        send(32'h0000_0013, 32'h0000_0800, 3'd0, 1, 32'h0000_0013);
        send(32'h0000_2023, 32'h0000_07FF, 3'd1, 1, 32'h7E00_2FA3);
        send(32'h0000_0063, 32'hFFFF_F000, 3'd2, 1, 32'h8000_0063);
        drain();

        orq_mode = 2;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] x;
            x = $urandom;
            send($urandom, {{20{x[11]}}, x[11:0]}, 3'd0, 0, 32'h0);
        end
        drain();

        orq_mode = 3;
        @(posedge clk); @(posedge clk); #1;
        send($urandom, 32'h10, 3'd0, 0, 32'h0);
        send($urandom, 32'h20, 3'd0, 0, 32'h0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_cnt", 32'(err_count), 32'd0);
        chk("async_rst_instr", out_instr, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        orq_mode = 0;
        @(posedge clk); #1;
        send(32'h0000_0013, 32'h0000_0005, 3'd0, 1, 32'h0050_0013);
        chk("post_rst_lat_1cyc", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("post_rst_lat_2cyc", 32'(out_valid), 32'd1);
        drain();

        for (int i = 0; i < 300; i++) send($urandom, $urandom, 3'd7, 0, 32'h0);
        drain();
        chk("saturated_cnt", 32'(err_count), 32'd255);

        orq_mode = 1;
        for (int i = 0; i < 10000; i++)
            send($urandom, rand_imm(), 3'($urandom_range(0, 7)), 0, 32'h0);
        orq_mode = 0;
        drain();
        chk("final_cnt", 32'(err_count), 32'(model_cnt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
